// File: rtl/assoc_cache.sv
// assoc_cache: set-associative write-back, write-allocate cache with true-LRU replacement.
//
// Processor port : address, data_in, bytemask, write, start_access -> access_done, data_out.
//                  Command inputs are held until access_done; start_access high in the
//                  access_done cycle starts the next access back-to-back.
// Downstream port: m_address, m_data_in, m_bytemask, m_write, m_start_access ->
//                  m_access_done, m_data_out. Same handshake; whole-block write-back then fill.
// Optional       : define ASSOC_CACHE_STATS_EN to add saturating 32-bit hit_count,
//                  miss_count and wb_count outputs.
// Reset          : reset is asynchronous active-low; clears valid/dirty/age and the FSM.
//                  Data and tag arrays are not reset.
module assoc_cache #(
  parameter int unsigned ADDR_WIDTH      = 20,
  parameter int unsigned SETS            = 8,
  parameter int unsigned WAYS            = 2,
  parameter int unsigned WORDS_PER_BLOCK = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [63:0]           data_in,
  input  logic [7:0]            bytemask,
  input  logic                  write,
  input  logic                  start_access,
  output logic                  access_done,
  output logic [63:0]           data_out,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [63:0]           m_data_in,
  output logic [7:0]            m_bytemask,
  output logic                  m_write,
  output logic                  m_start_access,
`ifdef ASSOC_CACHE_STATS_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count,
`endif
  input  logic                  m_access_done,
  input  logic [63:0]           m_data_out
);

  localparam int unsigned WB   = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned SB   = $clog2(SETS);
  localparam int unsigned AB   = $clog2(WAYS);
  localparam int unsigned WIW  = (WB > 0) ? WB : 1;
  localparam int unsigned SIW  = (SB > 0) ? SB : 1;
  localparam int unsigned WYW  = (AB > 0) ? AB : 1;
  localparam int unsigned TagW = ADDR_WIDTH - 3 - WB - SB;

  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StFill, StRespond} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [63:0]             wdata_q, wdata_d;
  logic [7:0]              mask_q, mask_d;
  logic                    write_q, write_d;
  logic [WIW-1:0]          cnt_q, cnt_d;
  logic [WYW-1:0]          victim_q, victim_d;
  logic                    m_start_q, m_start_d, m_write_q, m_write_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [63:0]             m_data_q, m_data_d;
  logic [7:0]              m_mask_q, m_mask_d;

  logic [63:0]             data_q  [SETS][WAYS][WORDS_PER_BLOCK];
  logic [TagW-1:0]         tag_q   [SETS][WAYS];
  logic [WAYS-1:0]         valid_q [SETS];
  logic [WAYS-1:0]         dirty_q [SETS];
  logic [WYW-1:0]          age_q   [SETS][WAYS];

  logic [SIW-1:0]          set_idx;
  logic [WIW-1:0]          word_idx;
  logic [TagW-1:0]         req_tag;
  logic                    hit, vic_found;
  logic [WYW-1:0]          hit_way, vic_way, acc_way, ref_age;
  logic                    done, miss, last_word, m_xfer_done, fill_we;
  logic [63:0]             rd_word, merged;
  logic                    unused_addr;

  assign unused_addr = ^address[2:0];

  assign word_idx = WIW'((addr_q >> 3) & ADDR_WIDTH'(WORDS_PER_BLOCK - 1));
  assign set_idx  = SIW'((addr_q >> (3 + WB)) & ADDR_WIDTH'(SETS - 1));
  assign req_tag  = TagW'(addr_q >> (3 + WB + SB));

  function automatic logic [ADDR_WIDTH-1:0] mk_addr(logic [TagW-1:0] t, logic [SIW-1:0] s,
                                                    logic [WIW-1:0] w);
    mk_addr = (ADDR_WIDTH'(t) << (3 + WB + SB)) | (ADDR_WIDTH'(s) << (3 + WB)) |
              (ADDR_WIDTH'(w) << 3);
  endfunction

  // Tag compare and victim choice: first invalid way, else oldest way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    vic_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[set_idx][w] && tag_q[set_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WYW'(w);
      end
      if (!vic_found && !valid_q[set_idx][w]) begin
        vic_found = 1'b1;
        vic_way   = WYW'(w);
      end
    end
    if (!vic_found) begin
      for (int unsigned w = 1; w < WAYS; w++) begin
        if (age_q[set_idx][w] > age_q[set_idx][vic_way]) vic_way = WYW'(w);
      end
    end
  end

  assign done        = (state_q == StLookup && hit) || (state_q == StRespond);
  assign miss        = (state_q == StLookup) && !hit;
  assign acc_way     = (state_q == StRespond) ? victim_q : hit_way;
  // A freshly filled way counts as oldest so every other way ages past it.
  assign ref_age     = (state_q == StRespond) ? WYW'(WAYS - 1) : age_q[set_idx][hit_way];
  assign rd_word     = data_q[set_idx][acc_way][word_idx];
  assign last_word   = (cnt_q == WIW'(WORDS_PER_BLOCK - 1));
  assign m_xfer_done = m_start_q && m_access_done;
  assign fill_we     = (state_q == StFill) && m_xfer_done;

  always_comb begin
    for (int b = 0; b < 8; b++) begin
      merged[8*b +: 8] = mask_q[b] ? wdata_q[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  assign access_done    = done;
  assign data_out       = done ? rd_word : 64'h0;
  assign m_start_access = m_start_q;
  assign m_address      = m_addr_q;
  assign m_data_in      = m_data_q;
  assign m_bytemask     = m_mask_q;
  assign m_write        = m_write_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    write_d   = write_q;
    cnt_d     = cnt_q;
    victim_d  = victim_q;
    m_start_d = m_start_q;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    m_mask_d  = m_mask_q;
    m_write_d = m_write_q;
    unique case (state_q)
      StIdle, StLookup, StRespond: begin
        if (state_q == StLookup && !hit) begin
          victim_d = vic_way;
          cnt_d    = '0;
          state_d  = (valid_q[set_idx][vic_way] && dirty_q[set_idx][vic_way]) ?
                     StWriteback : StFill;
        end else if (state_q == StIdle || done) begin
          state_d = StIdle;
          if (start_access) begin
            state_d = StLookup;
            addr_d  = address;
            wdata_d = data_in;
            mask_d  = bytemask;
            write_d = write;
          end
        end
      end
      StWriteback, StFill: begin
        if (!m_start_q) begin
          m_start_d = 1'b1;
          if (state_q == StWriteback) begin
            m_addr_d  = mk_addr(tag_q[set_idx][victim_q], set_idx, cnt_q);
            m_data_d  = data_q[set_idx][victim_q][cnt_q];
            m_mask_d  = 8'hFF;
            m_write_d = 1'b1;
          end else begin
            m_addr_d  = mk_addr(req_tag, set_idx, cnt_q);
            m_data_d  = 64'h0;
            m_mask_d  = 8'h00;
            m_write_d = 1'b0;
          end
        end else if (m_access_done) begin
          m_start_d = 1'b0;
          cnt_d     = cnt_q + 1'b1;
          if (last_word) begin
            cnt_d   = '0;
            state_d = (state_q == StWriteback) ? StFill : StRespond;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      victim_q  <= '0;
      m_start_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      m_mask_q  <= '0;
      m_write_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      victim_q  <= victim_d;
      m_start_q <= m_start_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      m_mask_q  <= m_mask_d;
      m_write_q <= m_write_d;
    end
  end

  // Line state. The victim is invalidated as soon as it is chosen so an abandoned
  // fill can never leave a half-written line marked valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      if (miss) begin
        valid_q[set_idx][vic_way] <= 1'b0;
        dirty_q[set_idx][vic_way] <= 1'b0;
      end
      if (fill_we && last_word) valid_q[set_idx][victim_q] <= 1'b1;
      if (done) begin
        if (write_q && (|mask_q)) dirty_q[set_idx][acc_way] <= 1'b1;
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WYW'(w) == acc_way) age_q[set_idx][w] <= '0;
          else if (age_q[set_idx][w] < ref_age) age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) data_q[set_idx][victim_q][cnt_q] <= m_data_out;
    if (fill_we && last_word) tag_q[set_idx][victim_q] <= req_tag;
    if (done && write_q) data_q[set_idx][acc_way][word_idx] <= merged;
  end

`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == StLookup && hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      if (state_q == StWriteback && m_xfer_done && last_word && wb_cnt_q != '1) begin
        wb_cnt_q <= wb_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif

endmodule
